// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and HI/LO write-enable bit positions for the mult/div unit
package muldiv_pkg;
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;
    localparam int HI_BIT = 1;
    localparam int LO_BIT = 0;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational step; acc={hi,lo}, shift-add for multiply, restoring shift-subtract for divide
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        acc_next = is_div ? (trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                          : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                          : {sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU owning HI/LO; in clock, reset(low), start, op, a, b, hilo_wr, wr_data, hilo_access; out hi, lo, busy, done, stall
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       hilo_wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hilo_access,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b, quo, rem;
    logic               is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d, done_q, done_d;
    logic               sa, sb, op_div;
    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );
    assign op_div = (op == MD_DIV) || (op == MD_DIVU);
    assign sa     = ((op == MD_MULT) || (op == MD_DIV)) && a[WIDTH-1];
    assign sb     = ((op == MD_MULT) || (op == MD_DIV)) && b[WIDTH-1];
    assign mag_a  = sa ? -a : a;
    assign mag_b  = sb ? -b : b;
    assign prod   = qneg_q ? -acc_q : acc_q;
    // A zero divisor leaves all-ones in the quotient magnitude, but the sign fix would corrupt it.
    assign quo    = bz_q ? '1 : (qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = (state_q == FIX);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    is_div_d = op_div;
                    qneg_d   = sa ^ sb;
                    rneg_d   = sa;
                    bz_d     = (b == '0);
                    // Multiplier (b) or dividend (a) enters the low half; the other operand is held aside.
                    acc_d    = {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
                    opnd_d   = op_div ? mag_b : mag_a;
                end else begin
                    hi_d = hilo_wr[HI_BIT] ? wr_data : hi_q;
                    lo_d = hilo_wr[LO_BIT] ? wr_data : lo_q;
                end
            end
            CALC: begin
                acc_d   = acc_step;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(ITER - 1)) ? FIX : CALC;
            end
            FIX: begin
                hi_d    = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? quo : prod[WIDTH-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign stall = busy & (start | hilo_access);
endmodule
